imem_load_ctrl: RTL and testbench

- Writable 64-word instruction store with a program-load sequencer. Replaces the fixed ROM in the single-cycle core's fetch path.
- An external loader streams a program into the store over a valid/ready handshake. The block zero-fills the unused tail, then releases the core, which starts fetching at address 0.
- The core fetch port keeps the same combinational read contract as the instruction ROM: 6-bit address in, N-bit word out.

---
 rtl/imem_load_ctrl_if.sv | 27 ++
 rtl/imem_load_ctrl.sv | 108 ++++++++++
 tb/tb_imem_load_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_ctrl_if.sv
// Fetch and program-load bundle for imem_load_ctrl. The master side is the core plus
// the external loader; the slave side is the instruction store.
interface imem_load_ctrl_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
) ();
  logic [AW-1:0] fetch_addr;
  logic [N-1:0]  fetch_q;
  logic          core_rst;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          load_valid;
  logic [N-1:0]  load_data;
  logic          load_ready;
  logic          load_done;
  logic          load_err;

  modport master (
    output fetch_addr, load_start, load_len, load_valid, load_data,
    input  fetch_q, core_rst, load_ready, load_done, load_err
  );

  modport slave (
    input  fetch_addr, load_start, load_len, load_valid, load_data,
    output fetch_q, core_rst, load_ready, load_done, load_err
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Writable instruction store with a load sequencer: streams a program in, zero-fills the
// tail, then releases the core, which fetches combinationally.
module imem_load_ctrl #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
) (
  input logic             clk,
  input logic             reset,
  imem_load_ctrl_if.slave bus
);
  localparam int unsigned   Depth   = 2 ** AW;
  localparam logic [AW-1:0] PtrLast = {AW{1'b1}};
  localparam logic [AW-1:0] PtrOne  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LenOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LenMax  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {StClear, StLoad, StDone, StRun} state_e;

  state_e        r_state, w_state_d;
  logic [AW-1:0] r_ptr, w_ptr_d;
  logic [AW:0]   r_len, w_len_d;
  logic [N-1:0]  r_mem [Depth];

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [N-1:0]  w_wdata;
  logic          w_len_ok;
  logic          w_last;

  assign w_len_ok = (bus.load_len != '0) && (bus.load_len <= LenMax);
  // Compare at AW+1 bits so len==64 maps to ptr==63 without overflow.
  assign w_last   = ({1'b0, r_ptr} == (r_len - LenOne));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StClear;
      r_ptr   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_len   <= w_len_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_len_d   = r_len;
    w_we      = 1'b0;
    w_waddr   = r_ptr;
    w_wdata   = '0;
    unique case (r_state)
      StClear: begin
        w_we = 1'b1;
        if (r_ptr == PtrLast) begin
          w_state_d = StDone;
        end else begin
          w_ptr_d = r_ptr + PtrOne;
        end
      end
      StLoad: begin
        if (bus.load_valid) begin
          w_we    = 1'b1;
          w_wdata = bus.load_data;
          if (w_last) begin
            if (r_len == LenMax) begin
              w_state_d = StDone;
            end else begin
              w_state_d = StClear;
              w_ptr_d   = r_len[AW-1:0];
            end
          end else begin
            w_ptr_d = r_ptr + PtrOne;
          end
        end
      end
      StDone: begin
        w_state_d = StRun;
        w_ptr_d   = '0;
      end
      StRun: begin
        if (bus.load_start && w_len_ok) begin
          w_len_d   = bus.load_len;
          w_ptr_d   = '0;
          w_state_d = StLoad;
        end
      end
      default: w_state_d = StClear;
    endcase
  end

  // Storage is deliberately not reset; the post-reset CLEAR pass zeroes every word.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    bus.core_rst   = (r_state != StRun);
    bus.load_ready = (r_state == StLoad);
    bus.load_done  = (r_state == StDone);
    bus.load_err   = (r_state == StRun) && bus.load_start && !w_len_ok;
    bus.fetch_q    = (r_state == StRun) ? r_mem[bus.fetch_addr] : '0;
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized scoreboard bench for imem_load_ctrl: expected fetch words and done/err cycle
// stamps are queued by the stimulus and consumed by a negedge monitor.
module tb_imem_load_ctrl;
  localparam int unsigned N  = 32;
  localparam int unsigned AW = 6;

  logic clk;
  logic reset;
  imem_load_ctrl_if #(.N(N), .AW(AW)) bus ();

  imem_load_ctrl #(.N(N), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic        rd_vld = 1'b0;
  logic [31:0] rd_q[$];
  int          done_q[$];
  int          err_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] stim[64];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endfunction

  // Monitor: consumes expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rd_q.size() == 0) flag("fetch_no_expect");
      else check($sformatf("fetch_q[%0d]", bus.fetch_addr), bus.fetch_q, rd_q.pop_front());
    end
    if (bus.load_done === 1'b1) begin
      if (done_q.size() == 0) flag("load_done");
      else check("load_done_cycle", cyc, done_q.pop_front());
    end
    if (bus.load_err === 1'b1) begin
      if (err_q.size() == 0) flag("load_err");
      else check("load_err_cycle", cyc, err_q.pop_front());
    end
    if (bus.load_done === 1'b1 && bus.load_err === 1'b1) flag("done_and_err");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    int p;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    reset = 1'b1;
    #2;
    check("rst_core_rst", bus.core_rst, 1);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_load_done", bus.load_done, 0);
    check("rst_load_err", bus.load_err, 0);
    check("rst_fetch_q", bus.fetch_q, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    p = cyc;
    done_q.push_back(p + 64);
    for (int a = 0; a < 64; a++) ref_mem[a] = '0;
    // Fetches during CLEAR must read zero regardless of address.
    for (int j = 0; j < 8; j++) begin
      bus.fetch_addr = 6'($urandom_range(0, 63));
      rd_vld = 1'b1;
      rd_q.push_back(32'h0);
      check("clear_core_rst", bus.core_rst, 1);
      @(posedge clk); #1;
    end
    rd_vld = 1'b0;
    while (cyc < p + 65) begin
      @(posedge clk); #1;
    end
    check("run_core_rst", bus.core_rst, 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) begin
      bus.fetch_addr = 6'(a);
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.load_data  = $urandom;
      rd_vld = 1'b1;
      rd_q.push_back(ref_mem[a]);
      @(posedge clk); #1;
    end
    rd_vld = 1'b0;
    bus.load_valid = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: alternate starting high, 2: random gaps.
  task automatic do_load(input int len, input int mode);
    int i;
    int k;
    logic v;
    bus.load_start = 1'b1;
    bus.load_len   = 7'(len);
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hdeadbeef;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    i = 0;
    k = 0;
    while (i < len) begin
      check("load_ready", bus.load_ready, 1);
      check("load_core_rst", bus.core_rst, 1);
      bus.fetch_addr = 6'($urandom_range(0, 63));
      #1;
      check("load_fetch_q", bus.fetch_q, 0);
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.load_valid = v;
      bus.load_data  = v ? stim[i] : $urandom;
      bus.load_start = ($urandom_range(0, 7) == 0);
      bus.load_len   = 7'($urandom_range(0, 127));
      @(posedge clk); #1;
      if (v) i++;
      k++;
    end
    bus.load_valid = 1'b0;
    done_q.push_back(cyc + 64 - len);
    for (int a = 0; a < 64; a++) ref_mem[a] = (a < len) ? stim[a] : 32'h0;
    for (int j = 0; j < 65 - len; j++) begin
      check("post_load_ready", bus.load_ready, 0);
      bus.load_start = ($urandom_range(0, 2) == 0);
      bus.load_len   = '0;
      @(posedge clk); #1;
    end
    bus.load_start = 1'b0;
    check("after_load_core_rst", bus.core_rst, 0);
  endtask

  task automatic bad_start(input logic [6:0] len);
    bus.load_start = 1'b1;
    bus.load_len   = len;
    err_q.push_back(cyc);
    check("bad_core_rst", bus.core_rst, 0);
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    check("bad_stay_run", bus.core_rst, 0);
    check("bad_no_ready", bus.load_ready, 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    #3;
    do_reset();
    read_all();

    for (int i = 0; i < 64; i++) stim[i] = 32'h10000000 + i;
    do_load(64, 0);
    read_all();
    bus.fetch_addr = 6'd5;
    #1;
    check("full_addr5", bus.fetch_q, 32'h10000005);
    bus.fetch_addr = 6'd63;
    #1;
    check("full_addr63", bus.fetch_q, 32'h1000003f);

    stim[0] = 32'hf8000001;
    stim[1] = 32'hf8008002;
    stim[2] = 32'hf8000203;
    do_load(3, 1);
    read_all();

    bad_start(7'd0);
    bad_start(7'd65);
    bad_start(7'd127);
    read_all();

    // Reset after four accepted words of a ten-word load.
    for (int i = 0; i < 10; i++) stim[i] = $urandom;
    bus.load_start = 1'b1;
    bus.load_len   = 7'd10;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = stim[i];
      @(posedge clk); #1;
    end
    check("midload_ready", bus.load_ready, 1);
    do_reset();
    read_all();

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 64);
      for (int i = 0; i < 64; i++) stim[i] = $urandom;
      do_load(len, 2);
      read_all();
      if ($urandom_range(0, 1) == 1) bad_start(7'($urandom_range(65, 127)));
    end

    repeat (2) @(posedge clk);
    #1;
    check("rd_q_drained", rd_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
